// File: rtl/nes_clkdiv.sv
// -----------------------------------------------------------------------------
// nes_clkdiv
//
// Purpose:
//    Derives the CPU and PPU timing of an NES-style system from the master
//    crystal clock. A CPU-cycle counter produces the ph0 level fed to the CPU
//    clock generator together with strobes at the start of each phase, and a
//    free-running PPU counter produces the dot-clock enable. The divider mode
//    (NTSC or PAL) is only switched at a CPU-cycle boundary so that a cycle
//    in progress is never stretched or cut short.
//
// Ports:
//    i_clk         master clock, all state changes on its rising edge
//    i_rst_n       asynchronous active-low reset (release is synchronised
//                  upstream)
//    i_run         1 = dividers advance, 0 = everything holds, strobes low
//    i_pal         requested divider mode: 0 = NTSC (CPU /12, PPU /4),
//                  1 = PAL (CPU /16, PPU /5)
//    o_ph0         CPU input clock level (low for the first LOW clocks of a
//                  CPU cycle, high for the rest)
//    o_ph1_start   one-clock strobe on the first clock of a CPU cycle
//    o_ph2_start   one-clock strobe on the first clock of ph0 high
//    o_ppu_ce      one-clock PPU dot enable
//    o_mode        divider mode currently in effect (0 NTSC, 1 PAL)
//    o_cyc_cnt     number of CPU cycles started since reset (wraps)
//
// Every output is driven directly by a flop.
// -----------------------------------------------------------------------------
module nes_clkdiv (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_run,
   input  logic        i_pal,
   output logic        o_ph0,
   output logic        o_ph1_start,
   output logic        o_ph2_start,
   output logic        o_ppu_ce,
   output logic        o_mode,
   output logic [15:0] o_cyc_cnt
);

   // CPU divider: last count of the cycle and length of the ph0-low phase
   localparam logic [3:0] CCNT_LAST_NTSC = 4'd11;   // divide by 12
   localparam logic [3:0] CCNT_LAST_PAL  = 4'd15;   // divide by 16
   localparam logic [3:0] LOW_NTSC       = 4'd5;
   localparam logic [3:0] LOW_PAL        = 4'd6;

   // PPU divider: last count of a dot
   localparam logic [2:0] PCNT_LAST_NTSC = 3'd3;    // divide by 4
   localparam logic [2:0] PCNT_LAST_PAL  = 3'd4;    // divide by 5

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [3:0]  r_ccnt;
   logic [2:0]  r_pcnt;
   logic        r_mode;
   logic [15:0] r_cyc_cnt;
   logic        r_ph0;
   logic        r_ph1_start;
   logic        r_ph2_start;
   logic        r_ppu_ce;

   // ---------------------------------------------------------------------
   // Next-state values for an advancing edge
   // ---------------------------------------------------------------------
   logic [3:0]  w_ccnt_last;
   logic        w_wrap;
   logic        w_mode_next;
   logic        w_mode_chg;
   logic [3:0]  w_ccnt_next;
   logic [3:0]  w_low_next;
   logic [2:0]  w_pcnt_last;
   logic [2:0]  w_pcnt_next;

   // The wrap decision uses the mode of the cycle now ending; >= keeps the
   // counter from running away should it ever hold an out-of-range value.
   assign w_ccnt_last = r_mode ? CCNT_LAST_PAL : CCNT_LAST_NTSC;
   assign w_wrap      = (r_ccnt >= w_ccnt_last);

   // The mode request is only looked at on the wrap edge, and the cycle that
   // starts on that edge already uses the newly sampled mode.
   assign w_mode_next = w_wrap ? i_pal : r_mode;
   assign w_mode_chg  = w_wrap && (i_pal != r_mode);
   assign w_ccnt_next = w_wrap ? 4'd0 : (r_ccnt + 4'd1);
   assign w_low_next  = w_mode_next ? LOW_PAL : LOW_NTSC;

   // The PPU counter free-runs across CPU cycles (in PAL the 16:5 ratio makes
   // it drift against the CPU cycle on purpose). It is only realigned when
   // the mode actually switches, so the new mode starts on a dot boundary.
   assign w_pcnt_last = r_mode ? PCNT_LAST_PAL : PCNT_LAST_NTSC;
   assign w_pcnt_next = (w_mode_chg || (r_pcnt >= w_pcnt_last)) ? 3'd0
                                                                 : (r_pcnt + 3'd1);

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   // Reset parks the CPU counter on its last NTSC count so that the first
   // advancing edge is a wrap: a fresh CPU cycle with mode sampled from i_pal.
   // The PPU counter is parked likewise so its first dot lines up with it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ccnt      <= CCNT_LAST_NTSC;
         r_pcnt      <= PCNT_LAST_NTSC;
         r_mode      <= 1'b0;
         r_cyc_cnt   <= 16'd0;
         r_ph0       <= 1'b0;
         r_ph1_start <= 1'b0;
         r_ph2_start <= 1'b0;
         r_ppu_ce    <= 1'b0;
      end else if (i_run) begin
         r_ccnt      <= w_ccnt_next;
         r_pcnt      <= w_pcnt_next;
         r_mode      <= w_mode_next;
         r_ph0       <= (w_ccnt_next >= w_low_next);
         r_ph1_start <= w_wrap;
         r_ph2_start <= (w_ccnt_next == w_low_next);
         r_ppu_ce    <= (w_pcnt_next == 3'd0);
         if (w_wrap) begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
         end
      end else begin
         // Frozen: counts, mode and ph0 keep their values, strobes are quiet.
         r_ph1_start <= 1'b0;
         r_ph2_start <= 1'b0;
         r_ppu_ce    <= 1'b0;
      end
   end

   assign o_ph0       = r_ph0;
   assign o_ph1_start = r_ph1_start;
   assign o_ph2_start = r_ph2_start;
   assign o_ppu_ce    = r_ppu_ce;
   assign o_mode      = r_mode;
   assign o_cyc_cnt   = r_cyc_cnt;

endmodule

// File: tb/tb_nes_clkdiv.sv
module tb_nes_clkdiv;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_run;
   logic        i_pal;
   logic        o_ph0;
   logic        o_ph1_start;
   logic        o_ph2_start;
   logic        o_ppu_ce;
   logic        o_mode;
   logic [15:0] o_cyc_cnt;

   int total;
   int bad;

   nes_clkdiv dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_run       (i_run),
      .i_pal       (i_pal),
      .o_ph0       (o_ph0),
      .o_ph1_start (o_ph1_start),
      .o_ph2_start (o_ph2_start),
      .o_ppu_ce    (o_ppu_ce),
      .o_mode      (o_mode),
      .o_cyc_cnt   (o_cyc_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        run;
      logic        pal;
      logic        ph0;
      logic        ph1;
      logic        ph2;
      logic        ppu;
      logic        mode;
      logic [15:0] cyc;
   } vec_t;

   vec_t tbl [24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string name, input logic ph0, input logic ph1,
                          input logic ph2, input logic ppu, input logic mode,
                          input logic [15:0] cyc);
      chk({name, ".ph0"},  32'(o_ph0),       32'(ph0));
      chk({name, ".ph1"},  32'(o_ph1_start), 32'(ph1));
      chk({name, ".ph2"},  32'(o_ph2_start), 32'(ph2));
      chk({name, ".ppu"},  32'(o_ppu_ce),    32'(ppu));
      chk({name, ".mode"}, 32'(o_mode),      32'(mode));
      chk({name, ".cyc"},  32'(o_cyc_cnt),   32'(cyc));
   endtask

   // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic run, input logic pal);
      @(negedge i_clk);
      i_run = run;
      i_pal = pal;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      int n;
      int ph2_at;
      int hi;
      bit got;
      bit mode_early;
      int e;

      total = 0;
      bad   = 0;

      // NTSC start-up table: edge k after reset release, hand-derived
      // (ph0 low for counts 0..4, ph2 at 5, dot every 4 edges, one CPU
      // cycle every 12 edges starting with the first edge).
      for (int k = 0; k < 24; k++) begin
         tbl[k].run  = 1'b1;
         tbl[k].pal  = 1'b0;
         tbl[k].ph0  = ((k % 12) >= 5);
         tbl[k].ph1  = ((k % 12) == 0);
         tbl[k].ph2  = ((k % 12) == 5);
         tbl[k].ppu  = ((k % 4) == 0);
         tbl[k].mode = 1'b0;
         tbl[k].cyc  = 16'(k / 12 + 1);
      end

      // ---- asynchronous reset, no clock edge involved ----
      i_run   = 1'b1;
      i_pal   = 1'b0;
      i_rst_n = 1'b1;
      #1 i_rst_n = 1'b0;
      #1;
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      $display("txn reset: ph0=%b mode=%b cyc=%h", o_ph0, o_mode, o_cyc_cnt);
      @(posedge i_clk);
      #1;
      chk_all("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      i_rst_n = 1'b1;

      // ---- NTSC table ----
      for (int k = 0; k < 24; k++) begin
         step(tbl[k].run, tbl[k].pal);
         $display("txn ntsc %0d: ph0=%b ph1=%b ph2=%b ppu=%b mode=%b cyc=%h",
                  k, o_ph0, o_ph1_start, o_ph2_start, o_ppu_ce, o_mode, o_cyc_cnt);
         chk_all($sformatf("ntsc%0d", k), tbl[k].ph0, tbl[k].ph1, tbl[k].ph2,
                 tbl[k].ppu, tbl[k].mode, tbl[k].cyc);
      end

      // ---- pal request mid-cycle: current cycle keeps 12 clocks ----
      step(1'b1, 1'b0);
      chk("sw.wrap_ph1", 32'(o_ph1_start), 32'd1);
      chk("sw.wrap_cyc", 32'(o_cyc_cnt), 32'd3);
      for (int s = 0; s < 3; s++) step(1'b1, 1'b0);  // counts 1,2,3
      n = 0; got = 0; mode_early = 0;
      while (!got && n < 40) begin
         step(1'b1, 1'b1);
         n++;
         if (o_ph1_start) got = 1;
         else if (o_mode) mode_early = 1;
      end
      $display("txn switch: tail=%0d mode=%b ppu=%b", n, o_mode, o_ppu_ce);
      chk("sw.tail_len", 32'(n), 32'd9);
      chk("sw.mode_early", 32'(mode_early), 32'd0);
      chk("sw.mode", 32'(o_mode), 32'd1);
      chk("sw.ppu_forced", 32'(o_ppu_ce), 32'd1);
      chk("sw.cyc", 32'(o_cyc_cnt), 32'd4);

      // ---- first PAL cycle: 16 clocks, ph0 low 6 / high 10 ----
      n = 0; got = 0; ph2_at = 0; hi = 0;
      while (!got && n < 40) begin
         step(1'b1, 1'b1);
         n++;
         if (o_ph2_start) ph2_at = n;
         if (o_ph0) hi++;
         if (o_ph1_start) got = 1;
      end
      $display("txn pal cycle: len=%0d ph2_at=%0d high=%0d", n, ph2_at, hi);
      chk("pal.len", 32'(n), 32'd16);
      chk("pal.ph2_at", 32'(ph2_at), 32'd6);
      chk("pal.high", 32'(hi), 32'd10);
      chk("pal.no_realign", 32'(o_ppu_ce), 32'd0);

      // ---- PAL drift: dots every 5 from the switch, coincide again at 80 ----
      for (int s = 1; s <= 64; s++) begin
         step(1'b1, 1'b1);
         e = 16 + s;
         chk($sformatf("drift%0d.ppu", e), 32'(o_ppu_ce), 32'((e % 5) == 0));
         chk($sformatf("drift%0d.ph1", e), 32'(o_ph1_start), 32'((e % 16) == 0));
      end
      $display("txn drift: ph1=%b ppu=%b cyc=%h", o_ph1_start, o_ppu_ce, o_cyc_cnt);
      chk("drift.cyc", 32'(o_cyc_cnt), 32'd9);

      // ---- back to NTSC at the next wrap ----
      for (int s = 1; s <= 16; s++) step(1'b1, 1'b0);
      chk_all("to_ntsc", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd10);
      for (int s = 1; s <= 5; s++) step(1'b1, 1'b0);
      chk_all("ph0_rise", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd10);

      // ---- freeze 7 clocks at count 5; pal wiggles are ignored ----
      for (int s = 0; s < 7; s++) begin
         step(1'b0, logic'(s % 2 == 0));
         $display("txn freeze %0d: ph0=%b cyc=%h", s, o_ph0, o_cyc_cnt);
         chk_all($sformatf("freeze%0d", s), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd10);
      end
      for (int s = 1; s <= 7; s++) begin
         step(1'b1, 1'b0);
         chk_all($sformatf("resume%0d", s), logic'(s != 7), logic'(s == 7), 1'b0,
                 logic'(s == 3 || s == 7), 1'b0, (s == 7) ? 16'd11 : 16'd10);
      end

      // ---- cycle counter wrap: preload 0xFFFF mid-cycle ----
      force dut.r_cyc_cnt = 16'hFFFF;
      for (int s = 1; s <= 10; s++) step(1'b1, 1'b0);
      release dut.r_cyc_cnt;
      step(1'b1, 1'b0);
      chk("cyc.preload", 32'(o_cyc_cnt), 32'h0000FFFF);
      step(1'b1, 1'b0);
      $display("txn cyc wrap: ph1=%b cyc=%h", o_ph1_start, o_cyc_cnt);
      chk("cyc.wrap_ph1", 32'(o_ph1_start), 32'd1);
      chk("cyc.wrap", 32'(o_cyc_cnt), 32'h00000000);
      for (int s = 1; s <= 12; s++) step(1'b1, 1'b0);
      chk("cyc.after_wrap", 32'(o_cyc_cnt), 32'h00000001);

      // ---- reset mid-cycle at count 8 (ph0 high, dot strobe active) ----
      for (int s = 1; s <= 8; s++) step(1'b1, 1'b0);
      chk("pre_rst.ph0", 32'(o_ph0), 32'd1);
      chk("pre_rst.ppu", 32'(o_ppu_ce), 32'd1);
      #2 i_rst_n = 1'b0;
      #1;
      $display("txn mid reset: ph0=%b ppu=%b cyc=%h", o_ph0, o_ppu_ce, o_cyc_cnt);
      chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int s = 0; s < 3; s++) begin
         step(1'b1, 1'b1);
         chk_all($sformatf("rst_hold%0d", s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      end
      i_rst_n = 1'b1;
      // first edge after release is a wrap straight into PAL
      for (int s = 0; s < 7; s++) begin
         step(1'b1, 1'b1);
         $display("txn pal start %0d: ph0=%b ph1=%b ph2=%b ppu=%b mode=%b cyc=%h",
                  s, o_ph0, o_ph1_start, o_ph2_start, o_ppu_ce, o_mode, o_cyc_cnt);
         chk_all($sformatf("pal_start%0d", s), logic'(s >= 6), logic'(s == 0),
                 logic'(s == 6), logic'(s % 5 == 0), 1'b1, 16'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
